regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file that succeeds the single-write, two-read `rf` used by the datapath. It provides:

- configurable width and depth;
- two read ports with same-cycle write bypass;
- two write ports with a defined collision priority;
- an optional hard-wired zero register;
- a per-register busy scoreboard for hazard detection;
- a halt-triggered dump sequencer that streams register contents over a valid/ready port, so the testbench and debug logic no longer depend on simulation-only `$display`.

## Interface

Parameters:
- `WIDTH`, 16, data width of each register
- `DEPTH`, 16, number of registers; power of two, ≥ 2
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override)
- `ZERO_REG`, 1. When 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `raddr_a`, `raddr_b`  in  AW  read addresses
- `rdata_a`, `rdata_b`  out  WIDTH  read data, combinational
- `busy_a`, `busy_b`  out  1  scoreboard bit of `raddr_a` / `raddr_b`, combinational
- `we0`, `we1`  in  1  write enables
- `waddr0`, `waddr1`  in  AW  write addresses
- `wdata0`, `wdata1`  in  WIDTH  write data
- `set_busy`  in  1  mark `busy_addr` busy at next edge
- `busy_addr`  in  AW  register to mark busy
- `hlt`  in  1  halt; a rising edge starts a dump
- `dump_valid`  out  1  dump beat valid
- `dump_ready`  in  1  consumer accepts beat
- `dump_idx`  out  AW  index of current beat
- `dump_data`  out  WIDTH  contents of `regs[dump_idx]`
- `dump_done`  out  1  one-cycle pulse after the last beat

## Operation

**Reset.** While `rst` is high:
- all registers and busy bits are 0;
- the dump FSM is in IDLE;
- `dump_valid`=0, `dump_idx`=0, `dump_done`=0;
- the `hlt` edge detector history is 0;
- writes and `set_busy` are ignored.

Because the outputs are combinational, `rdata_*`=0 and `busy_*`=0 during reset. Asserting `rst` mid-dump aborts the dump immediately; no `dump_done` is produced.

**Writes.**
- At the rising edge, `regs[waddrN] <= wdataN` for each asserted `weN`.
- If `we0` and `we1` target the same address, port 1 wins.
- With `ZERO_REG`=1, writes to address 0 are dropped.

**Read bypass.**
- `rdata_x` returns the value being written this cycle when a matching write is enabled; port 1 has priority over port 0.
- Otherwise `rdata_x` returns the stored value.
- With `ZERO_REG`=1, address 0 returns 0 regardless.

**Scoreboard.**
- An enabled write to an address clears that address's busy bit at the edge.
- `set_busy` sets `busy[busy_addr]`. If it coincides with a write to the same address, set wins.
- `busy_x` shows the stored bit; there is no bypass.

**Dump FSM.** States are IDLE, DUMP and DONE.
- A rising edge of `hlt` is detected as `hlt`=1 while the previous sampled value was 0.
- IDLE → DUMP when a rising edge of `hlt` is detected. `dump_idx` loads FIRST, where FIRST = 1 if `ZERO_REG` else 0.
- In DUMP, `dump_valid`=1. `dump_data` = stored `regs[dump_idx]`, without write bypass.
- On a `dump_valid` & `dump_ready` edge:
  - if `dump_idx`≠DEPTH−1, `dump_idx` increments;
  - otherwise the FSM goes to DONE.
- In DONE, `dump_done`=1 and `dump_valid`=0 for one cycle, then the FSM returns to IDLE with `dump_idx`=0.
- `hlt` edges in DUMP or DONE are ignored.
- Writes continue during a dump. A beat held by `dump_ready`=0 shows updated data on the cycle after a write to its index.

## Timing

- Read latency is 0 cycles, combinational from the address and the write ports.
- Write-to-stored latency is 1 edge.
- `hlt` rising in cycle n gives `dump_valid`=1 from cycle n+1.
- With `dump_ready` held at 1, the dump takes DEPTH−FIRST beats, one per cycle, followed by 1 DONE cycle.
- `dump_valid` never drops in DUMP without a handshake. `dump_idx` and `dump_valid` are stable while `dump_ready`=0.
- `rst` takes effect asynchronously. The first active edge is the first rising `clk` after `rst` deasserts.

## Test plan

- **Reset, then simultaneous write and read.** Apply reset. Then `we0`=1, `waddr0`=3, `wdata0`=16'hBEEF with `raddr_a`=3 → `rdata_a`=16'hBEEF the same cycle, and still BEEF after the edge with `we0`=0.
- **Write collision.** `we0`/`we1` both to address 5 with 16'h1111 / 16'h2222 → `regs[5]`=16'h2222. A bypass read of address 5 in that cycle returns 16'h2222.
- **Zero register.** With `ZERO_REG`=1, write 16'hFFFF to address 0, then `set_busy` on address 0 → `rdata_a`=0 and `busy_a`=0.
- **Scoreboard.** `set_busy` on address 7 → `busy_a`=1 for `raddr_a`=7. `set_busy` on 7 together with a write to 7 → stays 1. A write alone to 7 → 0 next cycle.
- **Dump with backpressure.** Load `regs[i]`=i·16'h0101, pulse `hlt`, and drive `dump_ready` in a 1,0,0,1… pattern → exactly 15 beats with idx 1..15 and matching data, held stable during stalls. Then one `dump_done` pulse. A second `hlt` pulse during the dump is ignored.
- **Reset mid-dump.** Assert `rst` at beat 6 → `dump_valid`=0 and all registers 0 immediately, no `dump_done`. A fresh `hlt` afterwards restarts the dump at idx 1.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read/two-write register file with busy scoreboard and halt-triggered dump port
// Reads bypass same-cycle writes (port 1 over port 0); the dump stream shows stored contents only.
module regfile_mp #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr0,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             set_busy,
  input  logic [AW-1:0]    busy_addr,
  input  logic             hlt,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done
);

  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} dumpState_t;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  dumpState_t       dumpState;
  logic             hltPrev;

  function automatic logic isZero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] readPort(
    input logic [AW-1:0] a, input logic inReset,
    input logic w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
    input logic [WIDTH-1:0] stored
  );
    if (isZero(a) || inReset) return '0;
    if (w1 && a1 == a)        return d1;
    if (w0 && a0 == a)        return d0;
    return stored;
  endfunction

  always_comb begin
    rdata_a = readPort(raddr_a, rst, we0, waddr0, wdata0, we1, waddr1, wdata1, regs[raddr_a]);
    rdata_b = readPort(raddr_b, rst, we0, waddr0, wdata0, we1, waddr1, wdata1, regs[raddr_b]);
  end

  assign busy_a    = busy[raddr_a];
  assign busy_b    = busy[raddr_b];
  assign dump_data = regs[dump_idx];

  // Statement order encodes priority: port 1 overrides port 0, set_busy overrides write-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (we0 && !isZero(waddr0)) begin
        regs[waddr0] <= wdata0;
        busy[waddr0] <= 1'b0;
      end
      if (we1 && !isZero(waddr1)) begin
        regs[waddr1] <= wdata1;
        busy[waddr1] <= 1'b0;
      end
      if (set_busy && !isZero(busy_addr)) busy[busy_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dumpState  <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_done  <= 1'b0;
      hltPrev    <= 1'b0;
    end else begin
      hltPrev <= hlt;
      case (dumpState)
        IDLE: begin
          dump_done <= 1'b0;
          if (hlt && !hltPrev) begin
            dumpState  <= DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= FIRST;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_idx != LAST) begin
              dump_idx <= dump_idx + AW'(1);
            end else begin
              dumpState  <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          dumpState <= IDLE;
          dump_done <= 1'b0;
          dump_idx  <= '0;
        end
        default: begin
          dumpState  <= IDLE;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
          dump_idx   <= '0;
        end
      endcase
    end
  end

endmodule
